dctrl_xcvr_sched: RTL
=====================

# dctrl_xcvr_sched

Half-duplex direction scheduler for one SN65MLVD-type bidirectional DCTRL channel. It arbitrates two bit-serial transmit requesters and drives the transceiver's D/DE/REn. It also inserts guarded turnaround gaps between drive and receive, and opens a bounded receive window when a transmission expects a response. It sits between the control-word serialisers and the transceiver pad model/IOB.

## Interface
Parameters:
- TURN_CYC, 4: cycles in each turnaround gap, with both sides released (1..15).
- RX_WINDOW, 64: maximum receive-window length in cycles (1..1023).
- IDLE_LEVEL, 1'b1: D value driven while idle.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid / b_valid  in  1  requester A/B has a bit on a_data / b_data.
- a_data / b_data  in  1  serial bit.
- a_last / b_last  in  1  current bit is the last of the frame.
- a_expect_rx / b_expect_rx  in  1  sampled with the first bit; a response follows.
- a_ready / b_ready  out  1  bit accepted this cycle.
- D  out  1  transceiver driver input.
- DE  out  1  driver enable, active high.
- REn  out  1  receiver enable, active low.
- R  in  1  transceiver receiver output; may be X or Z while REn=1.
- rx_stop  in  1  the downstream decoder has seen the end of the response.
- rx_data  out  1  registered copy of R.
- rx_valid  out  1  rx_data is valid.
- rx_timeout  out  1  one-cycle pulse when the window expired without rx_stop.
- busy  out  1  state is not IDLE.

## Operation
- States are RST_TURN, IDLE, TX, TURN_RX, RX and TURN_TX.
- Reset values: state=RST_TURN, DE=0, REn=1, D=IDLE_LEVEL, ready=0, rx_valid=0, rx_timeout=0, rx_data=0, busy=1, turn counter=0, rr pointer=A.
- RST_TURN: hold DE=0 and REn=1 for TURN_CYC cycles, then go to IDLE.
- IDLE: DE=1, REn=1, D=IDLE_LEVEL.
  - Grant when any valid is high.
  - If both are valid, the requester named by the rr pointer wins. The pointer then moves to the other requester.
  - The granted requester's expect_rx is latched. Go to TX.
- TX: DE=1, REn=1.
  - Only the granted requester's ready follows its valid. Each accepted bit appears on D on the next cycle.
  - The non-granted requester's ready stays 0 until the frame ends.
  - After the last bit is accepted:
    - expect_rx=1: hold that bit on D one cycle, then go to TURN_RX.
    - expect_rx=0: hold that bit on D one cycle, then go to IDLE.
  - A valid gap mid-frame holds the previous D bit. DE stays high and there is no timeout.
- TURN_RX: DE=0, REn=1 for TURN_CYC cycles, then go to RX. DE and REn are never asserted together.
- RX: DE=0, REn=0.
  - Each cycle, rx_data<=R and rx_valid<=1, starting with the first RX cycle.
  - The window counter counts 1..RX_WINDOW.
  - rx_stop=1 ends the window: go to TURN_TX.
  - Counter reaching RX_WINDOW with no rx_stop: pulse rx_timeout for one cycle, then go to TURN_TX.
  - rx_stop on the same cycle as window expiry counts as a normal stop, with no timeout.
- TURN_TX: DE=0, REn=1 for TURN_CYC cycles, then go to IDLE.
- busy=0 only in IDLE.
- Reset asserted mid-operation: all outputs return to their reset values immediately. An in-flight frame is dropped and its requester is not notified. The driver is released before the turnaround.

## Timing
- Grant latency: valid seen in IDLE, then ready in the following cycle (TX entry); one idle cycle minimum between frames.
- A frame of N bits with no gaps occupies N+1 TX cycles (last-bit hold). The last bit is on D for exactly one cycle.
- Driver-off to receiver-on is TURN_CYC cycles. The same gap applies the other way.
- rx_valid is deasserted in the cycle after leaving RX. rx_timeout aligns with the first TURN_TX cycle.
- Counters are 4-bit (turn) and 10-bit (window) and never wrap; they are cleared on every state entry.

## Configuration
- DCTRL_SCHED_STATS_EN defined: adds output frames_cnt[15:0] (completed TX frames) and timeouts_cnt[15:0] (rx_timeout pulses).
  - Both counters saturate at 16'hFFFF and reset to 0.
  - Both are cleared by an additional input stats_clr, synchronous to clk.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset release with TURN_CYC=4: DE=0 and REn=1 for 4 cycles, then DE=1 with D=1; busy falls after those 4 cycles.
- A sends 8'hA5 LSB-first, expect_rx=0: D shows 1,0,1,0,0,1,0,1 on consecutive cycles, last bit held one extra cycle, then IDLE. b_ready stays 0 throughout.
- A and B valid in the same cycle, twice: first grant goes to A, second to B; no two adjacent frames are granted to the same requester while both are pending.
- A with expect_rx=1, R toggling, rx_stop on RX cycle 10: 4 cycles with DE=0 and REn=1; 10 rx_valid cycles matching R; no rx_timeout; 4 turnaround cycles; back to IDLE. DE&~REn is never true.
- expect_rx=1 with rx_stop never asserted, RX_WINDOW=64: rx_timeout pulses once after 64 RX cycles, then TURN_TX; with STATS_EN, timeouts_cnt=1.
- rst_n dropped mid-TX at bit 3: DE=0 and REn=1 asynchronously in the same cycle; after release the RST_TURN sequence repeats and no stale bits appear on D.

Source files
------------

// File: rtl/dctrl_xcvr_sched.sv
// Half-duplex direction scheduler for one bidirectional DCTRL transceiver channel.
// Optional statistics counters are enabled with `define DCTRL_SCHED_STATS_EN.
module dctrl_xcvr_sched #(
  parameter int unsigned TURN_CYC   = 4,
  parameter int unsigned RX_WINDOW  = 64,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic        a_data,
  input  logic        a_last,
  input  logic        a_expect_rx,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic        b_data,
  input  logic        b_last,
  input  logic        b_expect_rx,
  output logic        b_ready,
  output logic        D,
  output logic        DE,
  output logic        REn,
  input  logic        R,
  input  logic        rx_stop,
  output logic        rx_data,
  output logic        rx_valid,
  output logic        rx_timeout,
  output logic        busy,
`ifdef DCTRL_SCHED_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] frames_cnt,
  output logic [15:0] timeouts_cnt,
`endif
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    RST_TURN = 3'd0,
    IDLE     = 3'd1,
    TX       = 3'd2,
    TURN_RX  = 3'd3,
    RX       = 3'd4,
    TURN_TX  = 3'd5
  } stateT;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [9:0] WIN_LAST  = 10'(RX_WINDOW - 1);

  stateT      state;
  logic [3:0] turnCnt;
  logic [9:0] winCnt;
  logic       grantB;
  logic       rrB;
  logic       expRx;
  logic       txOpen;

  logic       pickB;
  logic       selData;
  logic       selLast;
  logic       accept;
  logic       turnDone;
  logic       winDone;

  // Handshake: a bit transfers on a rising edge where valid and ready are both
  // high; ready is only ever raised for the granted requester while its frame
  // is open, and it mirrors that requester's valid combinationally.
  assign a_ready  = txOpen & ~grantB & a_valid;
  assign b_ready  = txOpen &  grantB & b_valid;
  assign accept   = a_ready | b_ready;

  assign pickB    = b_valid & (~a_valid | rrB);
  assign selData  = grantB ? b_data : a_data;
  assign selLast  = grantB ? b_last : a_last;
  assign turnDone = (turnCnt == TURN_LAST);
  assign winDone  = (winCnt == WIN_LAST);

  assign dbgState = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_TURN;
      DE         <= 1'b0;
      REn        <= 1'b1;
      D          <= IDLE_LEVEL;
      rx_data    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_timeout <= 1'b0;
      busy       <= 1'b1;
      turnCnt    <= 4'd0;
      winCnt     <= 10'd0;
      rrB        <= 1'b0;
      grantB     <= 1'b0;
      expRx      <= 1'b0;
      txOpen     <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      rx_timeout <= 1'b0;
      case (state)
        RST_TURN: begin
          if (turnDone) begin
            state <= IDLE;
            DE    <= 1'b1;
            D     <= IDLE_LEVEL;
            busy  <= 1'b0;
          end else begin
            turnCnt <= turnCnt + 4'd1;
          end
        end

        IDLE: begin
          if (a_valid || b_valid) begin
            state  <= TX;
            busy   <= 1'b1;
            grantB <= pickB;
            expRx  <= pickB ? b_expect_rx : a_expect_rx;
            txOpen <= 1'b1;
            // The round-robin pointer only matters, and only moves, on contention.
            if (a_valid && b_valid) begin
              rrB <= ~pickB;
            end
          end
        end

        TX: begin
          if (txOpen) begin
            if (accept) begin
              D <= selData;
              if (selLast) begin
                txOpen <= 1'b0;
              end
            end
          end else if (expRx) begin
            // Last bit has had its one hold cycle; release the driver.
            state   <= TURN_RX;
            DE      <= 1'b0;
            D       <= IDLE_LEVEL;
            turnCnt <= 4'd0;
          end else begin
            state <= IDLE;
            D     <= IDLE_LEVEL;
            busy  <= 1'b0;
          end
        end

        TURN_RX: begin
          if (turnDone) begin
            state  <= RX;
            REn    <= 1'b0;
            winCnt <= 10'd0;
          end else begin
            turnCnt <= turnCnt + 4'd1;
          end
        end

        RX: begin
          rx_data  <= R;
          rx_valid <= 1'b1;
          if (rx_stop || winDone) begin
            state      <= TURN_TX;
            REn        <= 1'b1;
            turnCnt    <= 4'd0;
            rx_timeout <= ~rx_stop;
          end else begin
            winCnt <= winCnt + 10'd1;
          end
        end

        TURN_TX: begin
          if (turnDone) begin
            state <= IDLE;
            DE    <= 1'b1;
            D     <= IDLE_LEVEL;
            busy  <= 1'b0;
          end else begin
            turnCnt <= turnCnt + 4'd1;
          end
        end

        default: begin
          state   <= RST_TURN;
          DE      <= 1'b0;
          REn     <= 1'b1;
          D       <= IDLE_LEVEL;
          busy    <= 1'b1;
          turnCnt <= 4'd0;
          txOpen  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCTRL_SCHED_STATS_EN
  logic frameDone;
  logic timeoutHit;

  assign frameDone  = (state == TX) && !txOpen;
  assign timeoutHit = (state == RX) && !rx_stop && winDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_cnt   <= 16'd0;
      timeouts_cnt <= 16'd0;
    end else if (stats_clr) begin
      frames_cnt   <= 16'd0;
      timeouts_cnt <= 16'd0;
    end else begin
      if (frameDone && (frames_cnt != 16'hFFFF)) begin
        frames_cnt <= frames_cnt + 16'd1;
      end
      if (timeoutHit && (timeouts_cnt != 16'hFFFF)) begin
        timeouts_cnt <= timeouts_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
